ram_march_bist: RTL and testbench

- Built-in self-test engine placed directly upstream of the single-port asynchronous-read RAM.
- Drives the RAM's addr, data_in, wr and cs, and consumes its data_out.
- Runs a March C- sequence and reports pass/fail with first-failure diagnostics.
- A system controller launches it and reads the result; during normal operation a mux outside this block gives the RAM ports back to functional logic.

---
 rtl/ram_march_bist.sv | 171 +++++++++++++++++
 tb/tb_ram_march_bist.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_march_bist.sv
// March C- built-in self-test engine for a single-port, asynchronous-read RAM.
// Issues one RAM op per clock and records the first read mismatch.
module ram_march_bist #(
  parameter int ADDR_SIZE    = 10,
  parameter int WORD_SIZE    = 8,
  parameter int MEMORY_SIZE  = 1024,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [ADDR_SIZE-1:0] fail_addr,
  output logic [WORD_SIZE-1:0] fail_exp,
  output logic [WORD_SIZE-1:0] fail_act,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [WORD_SIZE-1:0] ram_wdata,
  output logic                 ram_wr,
  output logic                 ram_cs,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEMORY_SIZE - 1);
  localparam logic [WORD_SIZE-1:0] ONES      = '1;

  state_t               state_q, state_d;
  logic [2:0]           elem_q, elem_d;
  logic                 phase_q, phase_d;
  logic                 fail_q, fail_d;
  logic [ADDR_SIZE-1:0] fail_addr_q, fail_addr_d;
  logic [WORD_SIZE-1:0] fail_exp_q, fail_exp_d;
  logic [WORD_SIZE-1:0] fail_act_q, fail_act_d;
  logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic                 ram_wr_q, ram_wr_d;
  logic                 ram_cs_q, ram_cs_d;

  logic                 mismatch;
  logic                 at_end;
  logic                 last_op;
  logic [WORD_SIZE-1:0] exp_rd;
  logic [2:0]           elem_nxt;

  // Elements M3 and M4 walk the address space downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= '0;
      phase_q     <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wr_q    <= 1'b0;
      ram_cs_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wr_q    <= ram_wr_d;
      ram_cs_q    <= ram_cs_d;
    end
  end

  // The RAM port registers hold the op in flight; each edge retires it and loads the next.
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_exp_d  = fail_exp_q;
    fail_act_d  = fail_act_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wr_d    = ram_wr_q;
    ram_cs_d    = ram_cs_q;
    mismatch    = 1'b0;
    at_end      = 1'b0;
    last_op     = 1'b0;
    elem_nxt    = elem_q + 3'd1;
    exp_rd      = (elem_q == 3'd2 || elem_q == 3'd4) ? ONES : '0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          elem_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_exp_d  = '0;
          fail_act_d  = '0;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          ram_wr_d    = 1'b1;
          ram_cs_d    = 1'b1;
        end
      end
      RUN: begin
        mismatch = !ram_wr_q && (ram_rdata != exp_rd);
        if (mismatch && !fail_q) begin
          fail_d      = 1'b1;
          fail_addr_d = ram_addr_q;
          fail_exp_d  = exp_rd;
          fail_act_d  = ram_rdata;
        end

        if (!phase_q && elem_q >= 3'd1 && elem_q <= 3'd4) begin
          phase_d     = 1'b1;
          ram_wr_d    = 1'b1;
          ram_wdata_d = elem_q[0] ? ONES : '0;
        end else begin
          phase_d = 1'b0;
          at_end  = elem_down(elem_q) ? (ram_addr_q == '0) : (ram_addr_q == LAST_ADDR);
          if (at_end) begin
            elem_d     = elem_nxt;
            ram_addr_d = elem_down(elem_nxt) ? LAST_ADDR : '0;
          end else begin
            ram_addr_d = elem_down(elem_q) ? ram_addr_q - ADDR_SIZE'(1)
                                           : ram_addr_q + ADDR_SIZE'(1);
          end
          ram_wr_d    = (elem_d == 3'd0);
          ram_wdata_d = '0;
        end

        last_op = (elem_q == 3'd5) && (ram_addr_q == LAST_ADDR);
        if (last_op || (mismatch && STOP_ON_FAIL != 0)) begin
          state_d     = DONE;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
          ram_wr_d    = 1'b0;
          ram_cs_d    = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        ram_wr_d = 1'b0;
        ram_cs_d = 1'b0;
      end
    endcase
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_wr    = ram_wr_q;
  assign ram_cs    = ram_cs_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist: two engines (abort / run-to-end) each driving
// a faultable RAM model, compared against an op list expanded from the March C- elements.
module tb_ram_march_bist;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int MS   = 16;
  localparam int NOPS = 10 * MS;

  logic clk;
  logic rst_n;
  logic startReg;
  int   sel;

  logic          startA [2];
  logic          busyA [2];
  logic          doneA [2];
  logic          failA [2];
  logic [AW-1:0] failAddrA [2];
  logic [DW-1:0] failExpA [2];
  logic [DW-1:0] failActA [2];
  logic [AW-1:0] ramAddrA [2];
  logic [DW-1:0] ramWdataA [2];
  logic          ramWrA [2];
  logic          ramCsA [2];
  logic [DW-1:0] ramRdataA [2];

  logic          faultEn [2];
  logic [AW-1:0] faultAddr [2];
  int            faultBit [2];
  logic          faultVal [2];

  logic [AW-1:0] opAddr [NOPS];
  logic          opWr [NOPS];
  logic [DW-1:0] opData [NOPS];
  logic [DW-1:0] opExp [NOPS];

  int testCount;
  int failCount;

  logic [16:0] obs;
  logic [19:0] diag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine 0 aborts on the first mismatch, engine 1 runs the whole sequence.
  for (genvar g = 0; g < 2; g++) begin : gDut
    logic [DW-1:0] mem [MS];

    assign startA[g] = startReg && (sel == g);

    ram_march_bist #(
      .ADDR_SIZE(AW), .WORD_SIZE(DW), .MEMORY_SIZE(MS), .STOP_ON_FAIL(g == 0 ? 1 : 0)
    ) dut (
      .clk(clk), .rst_n(rst_n), .start(startA[g]),
      .busy(busyA[g]), .done(doneA[g]), .fail(failA[g]),
      .fail_addr(failAddrA[g]), .fail_exp(failExpA[g]), .fail_act(failActA[g]),
      .ram_addr(ramAddrA[g]), .ram_wdata(ramWdataA[g]), .ram_wr(ramWrA[g]),
      .ram_cs(ramCsA[g]), .ram_rdata(ramRdataA[g])
    );

    always @(posedge clk)
      if (ramCsA[g] && ramWrA[g]) mem[ramAddrA[g]] <= ramWdataA[g];

    always_comb begin
      ramRdataA[g] = mem[ramAddrA[g]];
      if (faultEn[g] && ramAddrA[g] == faultAddr[g]) ramRdataA[g][faultBit[g]] = faultVal[g];
    end
  end

  always_comb begin
    obs  = {busyA[sel], doneA[sel], failA[sel], ramCsA[sel], ramWrA[sel],
            ramAddrA[sel], ramWdataA[sel]};
    diag = {failAddrA[sel], failExpA[sel], failActA[sel]};
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expand the six March C- elements into a flat list of RAM ops.
  task automatic buildOps();
    bit hasRead [6] = '{0, 1, 1, 1, 1, 1};
    bit rdOnes  [6] = '{0, 0, 1, 0, 1, 0};
    bit hasWr   [6] = '{1, 1, 1, 1, 1, 0};
    bit wrOnes  [6] = '{0, 1, 0, 1, 0, 0};
    bit down    [6] = '{0, 0, 0, 1, 1, 0};
    int n = 0;
    for (int e = 0; e < 6; e++) begin
      for (int s = 0; s < MS; s++) begin
        int a = down[e] ? MS - 1 - s : s;
        if (hasRead[e]) begin
          opAddr[n] = AW'(a); opWr[n] = 1'b0; opData[n] = '0;
          opExp[n]  = rdOnes[e] ? 8'hFF : 8'h00;
          n++;
        end
        if (hasWr[e]) begin
          opAddr[n] = AW'(a); opWr[n] = 1'b1;
          opData[n] = wrOnes[e] ? 8'hFF : 8'h00; opExp[n] = '0;
          n++;
        end
      end
    end
  endtask

  // Replays the op list on an ideal memory with the configured fault to find the first mismatch.
  task automatic predict(input int g, output int j, output logic [19:0] d);
    logic [DW-1:0] mm [MS];
    logic [DW-1:0] rv;
    j = -1;
    d = '0;
    for (int i = 0; i < NOPS; i++) begin
      if (opWr[i]) mm[opAddr[i]] = opData[i];
      else begin
        rv = mm[opAddr[i]];
        if (faultEn[g] && opAddr[i] == faultAddr[g]) rv[faultBit[g]] = faultVal[g];
        if (j < 0 && rv != opExp[i]) begin
          j = i;
          d = {opAddr[i], opExp[i], rv};
        end
      end
    end
  endtask

  task automatic applyStimulus(input int g, input int pulseAt, input int abortAt);
    int          j;
    int          endEdge;
    logic [19:0] dExp;
    logic        fExp;
    sel = g;
    predict(g, j, dExp);
    endEdge = (g == 0 && j >= 0) ? j + 1 : NOPS;
    @(negedge clk);
    startReg = 1'b1;
    @(negedge clk);
    startReg = 1'b0;
    checkOutput("diag_clr_on_start", 32'(diag), 32'h0);
    for (int i = 0; i < endEdge; i++) begin
      fExp = (j >= 0) && (i > j);
      checkOutput($sformatf("op%0d", i), 32'(obs),
                  32'({1'b1, 1'b0, fExp, 1'b1, opWr[i], opAddr[i], opData[i]}));
      if (j >= 0 && i == j + 1) checkOutput("diag_at_fail", 32'(diag), 32'(dExp));
      if (i == abortAt) begin
        #2 rst_n = 1'b0;
        #1 checkOutput("rst_async_obs", 32'(obs), 32'h0);
        checkOutput("rst_async_diag", 32'(diag), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          checkOutput("idle_after_rst", 32'(obs), 32'h0);
        end
        return;
      end
      startReg = (i == pulseAt);
      @(negedge clk);
    end
    startReg = 1'b0;
    checkOutput("end_state", 32'(obs), 32'({1'b0, 1'b1, j >= 0, 1'b0, 1'b0, 4'h0, 8'h00}));
    checkOutput("end_diag", 32'(diag), 32'(dExp));
    @(negedge clk);
    checkOutput("done_hold", 32'(obs), 32'({1'b0, 1'b1, j >= 0, 1'b0, 1'b0, 4'h0, 8'h00}));
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    startReg  = 1'b0;
    sel       = 0;
    rst_n     = 1'b0;
    for (int g = 0; g < 2; g++) begin
      faultEn[g] = 1'b0; faultAddr[g] = '0; faultBit[g] = 0; faultVal[g] = 1'b0;
    end
    buildOps();

    #1 checkOutput("reset_obs", 32'(obs), 32'h0);
    checkOutput("reset_diag", 32'(diag), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_obs", 32'(obs), 32'h0);

    applyStimulus(0, -1, -1);

    faultEn[0] = 1'b1; faultAddr[0] = 4'd5; faultBit[0] = 3; faultVal[0] = 1'b0;
    applyStimulus(0, -1, -1);
    checkOutput("sa0_fixed_diag", 32'(diag), 32'({4'd5, 8'hFF, 8'hF7}));

    faultEn[0] = 1'b0;
    applyStimulus(0, 40, -1);

    faultEn[1] = 1'b1; faultAddr[1] = 4'd0; faultBit[1] = 0; faultVal[1] = 1'b1;
    applyStimulus(1, -1, -1);
    checkOutput("sa1_fixed_diag", 32'(diag), 32'({4'd0, 8'h00, 8'h01}));

    for (int r = 0; r < 6; r++) begin
      int g = int'($urandom_range(1, 0));
      faultEn[g]   = ($urandom_range(3, 0) != 0);
      faultAddr[g] = AW'($urandom_range(MS - 1, 0));
      faultBit[g]  = int'($urandom_range(DW - 1, 0));
      faultVal[g]  = 1'($urandom);
      applyStimulus(g, int'($urandom_range(NOPS - 1, 0)), -1);
    end

    faultEn[0] = 1'b0;
    faultEn[1] = 1'b0;
    applyStimulus(0, -1, 70);
    applyStimulus(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
